// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        FAULT
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and memory.
interface fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/fetch_unit_if_id.sv
// IF/ID pipeline register: one entry of {valid, pc, instr, fault}.
import riscv_pkg::*;

module if_id_reg #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            consume,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [ILEN-1:0] load_instr,
    input  logic            load_fault,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] instr,
    output logic            fault
);

    // Flush beats load beats consume; payload is only rewritten by a real load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= ILEN'(NOP_INSTR);
            fault <= 1'b0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (consume)
                valid <= 1'b0;

            if (load && !flush) begin
                pc    <= load_pc;
                instr <= load_instr;
                fault <= load_fault;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID register,
// redirect handling and fetch-fault capture.
import riscv_pkg::*;

module fetch_unit #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int ILEN = riscv_pkg::ILEN
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  pc_cur,
    output logic [XLEN-1:0]  pc_next,
    output logic             pc_write,
    fetch_unit_if.master     imem,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [ILEN-1:0]  id_instr,
    output logic             id_fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] req_pc_q;
    logic            req_valid;
    logic            accept;
    logic            slot_free;
    logic            aligned;
    logic            ld;
    logic [XLEN-1:0] ld_pc;
    logic [ILEN-1:0] ld_instr;
    logic            ld_fault;

    assign slot_free      = !id_valid || id_ready;
    assign aligned        = (pc_cur[1:0] == 2'b00);
    assign accept         = req_valid && imem.req_ready;
    assign imem.req_valid = req_valid;
    assign imem.req_addr  = pc_cur;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // PC of the accepted request, tagged onto its response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            req_pc_q <= '0;
        else if (accept)
            req_pc_q <= pc_cur;
    end

    // Next state, request issue, PC update and IF/ID load; redirect overrides all.
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        pc_write  = 1'b0;
        pc_next   = '0;
        ld        = 1'b0;
        ld_pc     = pc_cur;
        ld_instr  = ILEN'(NOP_INSTR);
        ld_fault  = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (!redirect_valid && slot_free) begin
                    if (aligned) begin
                        req_valid = 1'b1;
                        if (imem.req_ready) begin
                            pc_write = 1'b1;
                            pc_next  = pc_cur + XLEN'(4);
                            state_d  = WAIT;
                        end
                    end else begin
                        // Misaligned PC: hand decode a faulting bubble instead of fetching.
                        ld       = 1'b1;
                        ld_fault = 1'b1;
                        state_d  = FAULT;
                    end
                end
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    ld       = 1'b1;
                    ld_pc    = req_pc_q;
                    ld_instr = imem.rsp_err ? ILEN'(NOP_INSTR) : imem.rsp_data;
                    ld_fault = imem.rsp_err;
                    state_d  = imem.rsp_err ? FAULT : REQ;
                end
            end
            DROP: begin
                if (imem.rsp_valid)
                    state_d = REQ;
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
            pc_write = 1'b1;
            pc_next  = redirect_pc;
            ld       = 1'b0;
            // A request still in flight must have its response swallowed.
            if ((state_q == WAIT || state_q == DROP) && !imem.rsp_valid)
                state_d = DROP;
            else
                state_d = REQ;
        end
    end

    if_id_reg #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_if_id (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (ld),
        .consume    (id_ready),
        .flush      (redirect_valid),
        .load_pc    (ld_pc),
        .load_instr (ld_instr),
        .load_fault (ld_fault),
        .valid      (id_valid),
        .pc         (id_pc),
        .instr      (id_instr),
        .fault      (id_fault)
    );

endmodule
